// File: rtl/layer6_stream_feeder.sv
// layer6_stream_feeder
// Walks the layer-6 feature map in raster order (column fastest), reads each
// position from the feature-map SRAM and streams it out as valid/ready beats
// through a 2-entry skid buffer.
//
// Build option: define LAYER6_FEEDER_PAD_EN to wrap the map in a one-pixel
// zero border ((WIDTH+2) x (HEIGHT+2) frame, border slots emit zero beats
// without touching the SRAM). Without it the frame is WIDTH x HEIGHT.
//
// Handshake: a beat transfers on a cycle where out_valid and out_ready are
// both 1. Once out_valid is raised, it and out_data stay put until that
// transfer happens; beats leave strictly in issue order.
//
// Pipeline: an issued slot (SRAM read or pad) returns its beat one cycle later.
// That beat is shown on out_data straight away when the skid buffer is empty,
// otherwise it joins the buffer behind older beats. A slot is only issued when
// the buffer is guaranteed to have room for it even if the sink stalls.
module layer6_stream_feeder #(
  parameter int DATA_W = 128,
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

`ifdef LAYER6_FEEDER_PAD_EN
  localparam int ROWS = HEIGHT + 2;
  localparam int COLS = WIDTH + 2;
`else
  localparam int ROWS = HEIGHT;
  localparam int COLS = WIDTH;
`endif
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // FSM state, visible by name for probes and bound checkers
  state_t state_q, state_d;

  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              p_valid_q;   // a slot was issued last cycle; its beat arrives now
  logic              p_pad_q;     // that slot was a pad slot
  logic [1:0]        cnt_q;       // skid buffer occupancy (0..2)
  logic [DATA_W-1:0] buf0_q;      // head of skid buffer
  logic [DATA_W-1:0] buf1_q;
  logic              done_q;

  logic              issue;
  logic              slot_pad;
  logic              last_slot;
  logic              start_accept;
  logic              fire;
  logic              final_beat;
  logic [1:0]        total;
  logic [ADDR_W-1:0] lin_addr;
  logic [DATA_W-1:0] incoming;

  // Slot position decode and SRAM address for the current counters
  always_comb begin
    last_slot = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
`ifdef LAYER6_FEEDER_PAD_EN
    slot_pad  = (row_q == '0) || (row_q == RW'(ROWS - 1)) ||
                (col_q == '0) || (col_q == CW'(COLS - 1));
    lin_addr  = (ADDR_W'(row_q) - ADDR_W'(1)) * ADDR_W'(WIDTH) +
                (ADDR_W'(col_q) - ADDR_W'(1));
`else
    slot_pad  = 1'b0;
    lin_addr  = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
`endif
  end

  // Beat bookkeeping: in-flight plus buffered beats, and the transfer strobe
  always_comb begin
    total        = cnt_q + {1'b0, p_valid_q};
    incoming     = p_pad_q ? '0 : rd_data;
    out_valid    = (cnt_q != 2'd0) || p_valid_q;
    out_data     = (cnt_q != 2'd0) ? buf0_q : (p_valid_q ? incoming : '0);
    fire         = out_valid && out_ready;
    start_accept = (state_q == S_IDLE) && start && !done_q;
    final_beat   = (state_q == S_DRAIN) && (total == 2'd1) && fire;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_accept)       state_d = S_STREAM;
      S_STREAM: if (issue && last_slot) state_d = S_DRAIN;
      S_DRAIN:  if (final_beat)         state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // FSM outputs: issue only when the buffer can absorb the new beat under stall
  always_comb begin
    busy    = (state_q != S_IDLE);
    issue   = (state_q == S_STREAM) && (total <= 2'd1);
    rd_en   = issue && !slot_pad;
    rd_addr = rd_en ? lin_addr : '0;
    done    = done_q;
  end

  // Raster counters: cleared on accepted start, advanced per issued slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (start_accept) begin
      row_q <= '0;
      col_q <= '0;
    end else if (issue) begin
      if (col_q == CW'(COLS - 1)) begin
        col_q <= '0;
        row_q <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // In-flight slot tag and end-of-frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_pad_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      p_valid_q <= issue;
      p_pad_q   <= issue && slot_pad;
      done_q    <= final_beat;
    end
  end

  // Skid buffer: keep unsent beats in order, head in buf0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (p_valid_q && !fire) begin
            buf0_q <= incoming;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (fire) begin
            if (p_valid_q) buf0_q <= incoming;
            cnt_q <= {1'b0, p_valid_q};
          end else if (p_valid_q) begin
            buf1_q <= incoming;
            cnt_q  <= 2'd2;
          end
        end
        2'd2: begin
          if (fire) begin
            buf0_q <= buf1_q;
            cnt_q  <= 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_layer6_stream_feeder.sv
// Bench for layer6_stream_feeder with a 4x3 map and SRAM word a = a + 100.
// Build with LAYER6_FEEDER_PAD_EN defined to exercise the zero-border frame.
module tb_layer6_stream_feeder;
  localparam int DATA_W = 16;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int ADDR_W = 10;
`ifdef LAYER6_FEEDER_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int FR_W = WIDTH + 2;
  localparam int FR_H = HEIGHT + 2;
`else
  localparam bit PAD = 1'b0;
  localparam int FR_W = WIDTH;
  localparam int FR_H = HEIGHT;
`endif
  localparam int N_SLOTS = FR_W * FR_H;
  localparam int N_READS = WIDTH * HEIGHT;
  localparam int LIMIT   = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    int stall_from;
    int stall_len;
    int restart_at;
    bit rnd;
    int exp_done;
  } vec_t;
  vec_t vecs[6];

  // clock / reset block
  always #5 clk = ~clk;

  layer6_stream_feeder #(
    .DATA_W(DATA_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // SRAM model: data one cycle after rd_en, junk otherwise
  always @(posedge clk) begin
    if (rd_en) rd_data <= DATA_W'(32'(rd_addr) + 100);
    else       rd_data <= DATA_W'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: expected beat list from the frame geometry
  task automatic load_expected();
    exp_q.delete();
    for (int r = 0; r < FR_H; r++) begin
      for (int c = 0; c < FR_W; c++) begin
        if (PAD && (r == 0 || r == FR_H - 1 || c == 0 || c == FR_W - 1))
          exp_q.push_back('0);
        else if (PAD)
          exp_q.push_back(DATA_W'((r - 1) * WIDTH + (c - 1) + 100));
        else
          exp_q.push_back(DATA_W'(r * WIDTH + c + 100));
      end
    end
  endtask

  // driver + monitor for one frame; called just after a rising edge (cycle 0)
  task automatic run_frame(input vec_t v);
    int beat_idx = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    bit prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] want;
    int exp_cyc;
    load_expected();
    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      start = (cyc == 0) || (cyc == v.restart_at);
      if (v.rnd) out_ready = ($urandom_range(0, 3) != 0);
      else       out_ready = !(cyc >= v.stall_from && cyc < v.stall_from + v.stall_len);
      @(negedge clk);
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(beat_idx), 32'(N_SLOTS - 1));
        end else begin
          want = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(want));
          if (!v.rnd) begin
            exp_cyc = 2 + beat_idx + ((beat_idx >= v.stall_from - 2) ? v.stall_len : 0);
            chk("beat_cycle", 32'(cyc), 32'(exp_cyc));
          end
        end
        beat_idx++;
      end
      if (rd_en) rd_cnt++;
      if (!v.rnd) begin
        chk("busy", 32'(busy), 32'(cyc >= 1 && cyc < v.exp_done));
        chk("done", 32'(done), 32'(cyc == v.exp_done));
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      @(posedge clk); #1;
      if (done_at >= 0 && cyc >= done_at + 3) break;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_at >= 0), 32'd1);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("beats_left", 32'(exp_q.size()), 32'd0);
    chk("beat_count", 32'(beat_idx), 32'(N_SLOTS));
    chk("rd_count", 32'(rd_cnt), 32'(N_READS));
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    // reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // table of frame scenarios
    vecs[0] = '{stall_from: 1000, stall_len: 0, restart_at: -1, rnd: 0, exp_done: N_SLOTS + 2};
    vecs[1] = '{stall_from: 5, stall_len: 3, restart_at: -1, rnd: 0, exp_done: N_SLOTS + 5};
    vecs[2] = '{stall_from: 1000, stall_len: 0, restart_at: 6, rnd: 0, exp_done: N_SLOTS + 2};
    vecs[3] = '{stall_from: 1000, stall_len: 0, restart_at: N_SLOTS + 2, rnd: 0, exp_done: N_SLOTS + 2};
    vecs[4] = '{stall_from: 1000, stall_len: 0, restart_at: -1, rnd: 1, exp_done: 0};
    vecs[5] = '{stall_from: 1000, stall_len: 0, restart_at: 7, rnd: 1, exp_done: 0};
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
      repeat (2) @(posedge clk);
      #1;
    end

    // reset in the middle of a frame
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      start = (cyc == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outputs", {28'd0, busy, done, rd_en, out_valid}, 32'd0);
    chk("mid_rst_addr_data", {6'd0, rd_addr, out_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (out_valid || done || busy || rd_en) bad++;
    end
    chk("quiet_after_rst", 32'(bad), 32'd0);
    @(posedge clk); #1;
    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
